// File: rtl/branch_predict_unit.sv
// -----------------------------------------------------------------------------
// branch_predict_unit
//
// Resolves conditional branches and jumps in execute and registers the outcome
// for the fetch/redirect logic. A direct-mapped table of 2-bit saturating
// counters is updated by resolved branches and supplies a combinational
// taken prediction for the fetch PC.
//
// Optional feature: define BRANCH_PERF_CNT_EN to add the perf_branches and
// perf_mispredicts counters and their output ports.
//
// Ports:
//   CLK, RST            clock, synchronous active-high reset
//   f_pc                fetch PC for the prediction lookup
//   f_pred_taken        bit 1 of the counter addressed by f_pc
//   ex_valid, ex_stall  execute-stage handshake; fire = valid && !stall
//   ex_opcode/funct3    instruction fields of the execute instruction
//   ex_pc, ex_rs1/rs2   PC and register operands
//   ex_pred_taken       prediction that travelled with the instruction
//   ex_*_target         precomputed branch / jal / jalr targets
//   res_*               registered resolution result, 1 cycle after fire
//   perf_*              (optional) branch and mispredict event counters
// -----------------------------------------------------------------------------
module branch_predict_unit #(
    parameter int         XLEN     = 32,
    parameter int         IDX_BITS = 6,
    parameter logic [1:0] CNT_INIT = 2'b01
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic [XLEN-1:0] f_pc,
    output logic            f_pred_taken,
    input  logic            ex_valid,
    input  logic            ex_stall,
    input  logic [6:0]      ex_opcode,
    input  logic [2:0]      ex_funct3,
    input  logic [XLEN-1:0] ex_pc,
    input  logic [XLEN-1:0] ex_rs1,
    input  logic [XLEN-1:0] ex_rs2,
    input  logic            ex_pred_taken,
    input  logic [XLEN-1:0] ex_br_target,
    input  logic [XLEN-1:0] ex_jal_target,
    input  logic [XLEN-1:0] ex_jalr_target,
    output logic            res_valid,
    output logic [2:0]      res_pcSource,
    output logic            res_redirect,
    output logic [XLEN-1:0] res_redirect_pc,
    output logic            res_taken
`ifdef BRANCH_PERF_CNT_EN
    ,
    output logic [31:0]     perf_branches,
    output logic [31:0]     perf_mispredicts
`endif
);

    localparam int         ENTRIES = 1 << IDX_BITS;
    localparam logic [6:0] OP_BR   = 7'b1100011;
    localparam logic [6:0] OP_JALR = 7'b1100111;
    localparam logic [6:0] OP_JAL  = 7'b1101111;

    // Full-table synchronous reset keeps this in flops rather than RAM.
    logic [1:0] cnt_tbl [ENTRIES];

    logic                fire;
    logic [IDX_BITS-1:0] look_idx;
    logic [IDX_BITS-1:0] upd_idx;
    logic                f3_ok;
    logic                br_taken;
    logic                upd_en;
    logic [1:0]          cnt_cur;
    logic [1:0]          cnt_nxt;
    logic [XLEN-1:0]     pc_plus4;
    logic [2:0]          nxt_pcs;
    logic                nxt_redir;
    logic                nxt_taken;
    logic [XLEN-1:0]     nxt_rpc;

    // Word-aligned PCs: bits [1:0] never select an entry.
    assign look_idx     = f_pc[IDX_BITS+1:2];
    assign upd_idx      = ex_pc[IDX_BITS+1:2];
    assign f_pred_taken = cnt_tbl[look_idx][1];

    assign fire     = ex_valid && !ex_stall;
    assign pc_plus4 = ex_pc + XLEN'(4);

    // Branch condition; 010/011 are not branch encodings.
    always_comb begin
        f3_ok    = 1'b1;
        br_taken = 1'b0;
        case (ex_funct3)
            3'b000:  br_taken = (ex_rs1 == ex_rs2);
            3'b001:  br_taken = (ex_rs1 != ex_rs2);
            3'b100:  br_taken = ($signed(ex_rs1) <  $signed(ex_rs2));
            3'b101:  br_taken = ($signed(ex_rs1) >= $signed(ex_rs2));
            3'b110:  br_taken = (ex_rs1 <  ex_rs2);
            3'b111:  br_taken = (ex_rs1 >= ex_rs2);
            default: f3_ok    = 1'b0;
        endcase
    end

    // Next result; default is the fall-through case for non-control opcodes.
    always_comb begin
        nxt_pcs   = 3'd0;
        nxt_redir = 1'b0;
        nxt_taken = 1'b0;
        nxt_rpc   = pc_plus4;
        case (ex_opcode)
            OP_BR: begin
                if (f3_ok) begin
                    nxt_taken = br_taken;
                    nxt_pcs   = br_taken ? 3'd2 : 3'd0;
                    nxt_redir = (br_taken != ex_pred_taken);
                    nxt_rpc   = br_taken ? ex_br_target : pc_plus4;
                end else begin
                    // Bad encoding resolves not-taken; undo a taken guess.
                    nxt_redir = ex_pred_taken;
                end
            end
            OP_JALR: begin
                nxt_pcs   = 3'd1;
                nxt_redir = 1'b1;
                nxt_taken = 1'b1;
                nxt_rpc   = {ex_jalr_target[XLEN-1:1], 1'b0};
            end
            OP_JAL: begin
                nxt_pcs   = 3'd3;
                nxt_redir = 1'b1;
                nxt_taken = 1'b1;
                nxt_rpc   = ex_jal_target;
            end
            default: ;
        endcase
    end

    assign upd_en  = fire && (ex_opcode == OP_BR) && f3_ok;
    assign cnt_cur = cnt_tbl[upd_idx];

    always_comb begin
        cnt_nxt = cnt_cur;
        if (br_taken) begin
            if (cnt_cur != 2'b11) cnt_nxt = cnt_cur + 2'b01;
        end else begin
            if (cnt_cur != 2'b00) cnt_nxt = cnt_cur - 2'b01;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            res_valid       <= 1'b0;
            res_pcSource    <= 3'd0;
            res_redirect    <= 1'b0;
            res_redirect_pc <= '0;
            res_taken       <= 1'b0;
            for (int i = 0; i < ENTRIES; i++) cnt_tbl[i] <= CNT_INIT;
        end else begin
            res_valid <= fire;
            if (fire) begin
                res_pcSource    <= nxt_pcs;
                res_redirect    <= nxt_redir;
                res_redirect_pc <= nxt_rpc;
                res_taken       <= nxt_taken;
            end
            // Lookup is combinational off the old array: read-before-write.
            if (upd_en) cnt_tbl[upd_idx] <= cnt_nxt;
        end
    end

`ifdef BRANCH_PERF_CNT_EN
    always_ff @(posedge CLK) begin
        if (RST) begin
            perf_branches    <= '0;
            perf_mispredicts <= '0;
        end else if (upd_en) begin
            perf_branches <= perf_branches + 32'd1;
            if (nxt_redir) perf_mispredicts <= perf_mispredicts + 32'd1;
        end
    end
`endif

    // Bits that never feed logic: PC bits outside the index, jalr bit 0.
    logic unused_bits;
    assign unused_bits = ^{f_pc[XLEN-1:IDX_BITS+2], f_pc[1:0], ex_jalr_target[0]};

endmodule

// File: tb/tb_branch_predict_unit.sv
// -----------------------------------------------------------------------------
// tb_branch_predict_unit
//
// Directed stimulus with hand-computed expectations. Each fired instruction
// pushes its expected result into a queue; a monitor on the falling edge pops
// and compares whenever res_valid is high. Prediction and reset values are
// checked directly from the stimulus process.
// -----------------------------------------------------------------------------
module tb_branch_predict_unit;

    localparam logic [6:0] OP_BR   = 7'b1100011;
    localparam logic [6:0] OP_JALR = 7'b1100111;
    localparam logic [6:0] OP_JAL  = 7'b1101111;
    localparam logic [6:0] OP_ALU  = 7'b0110011;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic [31:0] f_pc = '0;
    logic        f_pred_taken;
    logic        ex_valid = 1'b0;
    logic        ex_stall = 1'b0;
    logic [6:0]  ex_opcode = '0;
    logic [2:0]  ex_funct3 = '0;
    logic [31:0] ex_pc = '0;
    logic [31:0] ex_rs1 = '0;
    logic [31:0] ex_rs2 = '0;
    logic        ex_pred_taken = 1'b0;
    logic [31:0] ex_br_target = '0;
    logic [31:0] ex_jal_target = '0;
    logic [31:0] ex_jalr_target = '0;
    logic        res_valid;
    logic [2:0]  res_pcSource;
    logic        res_redirect;
    logic [31:0] res_redirect_pc;
    logic        res_taken;
`ifdef BRANCH_PERF_CNT_EN
    logic [31:0] perf_branches;
    logic [31:0] perf_mispredicts;
`endif

    branch_predict_unit #(.XLEN(32), .IDX_BITS(6), .CNT_INIT(2'b01)) dut (
        .CLK(CLK), .RST(RST),
        .f_pc(f_pc), .f_pred_taken(f_pred_taken),
        .ex_valid(ex_valid), .ex_stall(ex_stall),
        .ex_opcode(ex_opcode), .ex_funct3(ex_funct3),
        .ex_pc(ex_pc), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2),
        .ex_pred_taken(ex_pred_taken),
        .ex_br_target(ex_br_target), .ex_jal_target(ex_jal_target),
        .ex_jalr_target(ex_jalr_target),
        .res_valid(res_valid), .res_pcSource(res_pcSource),
        .res_redirect(res_redirect), .res_redirect_pc(res_redirect_pc),
        .res_taken(res_taken)
`ifdef BRANCH_PERF_CNT_EN
        , .perf_branches(perf_branches), .perf_mispredicts(perf_mispredicts)
`endif
    );

    always #5 CLK = ~CLK;

    typedef struct {
        string       name;
        logic [2:0]  pcs;
        logic        redir;
        logic [31:0] rpc;
        logic        taken;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   passes = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    // Monitor: every res_valid cycle must match the oldest pending expectation.
    always @(negedge CLK) begin
        if (res_valid === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                $display("FAIL unexpected_res: res_valid=1 with nothing issued (pcs=%0d rpc=0x%08h)",
                         res_pcSource, res_redirect_pc);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if (res_pcSource === e.pcs && res_redirect === e.redir &&
                    res_redirect_pc === e.rpc && res_taken === e.taken)
                    passes++;
                else
                    $display("FAIL %s: got pcs=%0d redir=%0b rpc=0x%08h taken=%0b expected pcs=%0d redir=%0b rpc=0x%08h taken=%0b",
                             e.name, res_pcSource, res_redirect, res_redirect_pc, res_taken,
                             e.pcs, e.redir, e.rpc, e.taken);
            end
        end
    end

    // Only the target matching the opcode is meaningful; others get poison.
    task automatic drive(input logic [6:0] op, input logic [2:0] f3, input logic [31:0] pc,
                         input logic [31:0] rs1, input logic [31:0] rs2,
                         input logic pred, input logic [31:0] tgt);
        ex_opcode      = op;
        ex_funct3      = f3;
        ex_pc          = pc;
        ex_rs1         = rs1;
        ex_rs2         = rs2;
        ex_pred_taken  = pred;
        ex_br_target   = (op == OP_BR)   ? tgt : 32'hBAD0_0010;
        ex_jal_target  = (op == OP_JAL)  ? tgt : 32'hBAD0_0020;
        ex_jalr_target = (op == OP_JALR) ? tgt : 32'hBAD0_0031;
    endtask

    task automatic issue(input string name, input logic [6:0] op, input logic [2:0] f3,
                         input logic [31:0] pc, input logic [31:0] rs1, input logic [31:0] rs2,
                         input logic pred, input logic [31:0] tgt,
                         input logic [2:0] e_pcs, input logic e_redir,
                         input logic [31:0] e_rpc, input logic e_taken);
        exp_t e;
        e.name = name; e.pcs = e_pcs; e.redir = e_redir; e.rpc = e_rpc; e.taken = e_taken;
        drive(op, f3, pc, rs1, rs2, pred, tgt);
        exp_q.push_back(e);
        ex_valid = 1'b1;
        @(posedge CLK); #1;
        ex_valid = 1'b0;
    endtask

    task automatic check_pred(input string name, input logic [31:0] pc, input logic exp);
        f_pc = pc;
        #1;
        chk(name, {31'd0, f_pred_taken}, {31'd0, exp});
    endtask

    initial begin
        // Reset state
        repeat (2) @(posedge CLK);
        #1 RST = 1'b0;
        chk("rst_valid",    {31'd0, res_valid}, 32'd0);
        chk("rst_pcs",      {29'd0, res_pcSource}, 32'd0);
        chk("rst_redirect", {31'd0, res_redirect}, 32'd0);
        chk("rst_rpc",      res_redirect_pc, 32'd0);
        chk("rst_taken",    {31'd0, res_taken}, 32'd0);
        check_pred("rst_pred_100", 32'h100, 1'b0);

        // Training index 0 (pc 0x100): 1 -> 2 -> 3 -> 3 -> 3 -> 2 -> 1
        issue("beq_first", OP_BR, 3'b000, 32'h100, 5, 5, 1'b0, 32'h140, 3'd2, 1'b1, 32'h140, 1'b1);
        check_pred("pred_cnt2", 32'h100, 1'b1);
        issue("beq_t2", OP_BR, 3'b000, 32'h100, 5, 5, 1'b1, 32'h140, 3'd2, 1'b0, 32'h140, 1'b1);
        issue("beq_t3", OP_BR, 3'b000, 32'h100, 5, 5, 1'b1, 32'h140, 3'd2, 1'b0, 32'h140, 1'b1);
        issue("beq_t4", OP_BR, 3'b000, 32'h100, 5, 5, 1'b1, 32'h140, 3'd2, 1'b0, 32'h140, 1'b1);
        check_pred("pred_sat3", 32'h100, 1'b1);
        issue("bne_nt1", OP_BR, 3'b001, 32'h100, 5, 5, 1'b1, 32'h140, 3'd0, 1'b1, 32'h104, 1'b0);
        check_pred("pred_after_nt1", 32'h100, 1'b1);
        issue("bne_nt2", OP_BR, 3'b001, 32'h100, 5, 5, 1'b1, 32'h140, 3'd0, 1'b1, 32'h104, 1'b0);
        check_pred("pred_after_nt2", 32'h100, 1'b0);

        // Signed vs unsigned at pc 0x204 (index 1, counter 1)
        issue("blt",  OP_BR, 3'b100, 32'h204, 32'hFFFF_FFFF, 1, 1'b0, 32'h250, 3'd2, 1'b1, 32'h250, 1'b1);
        issue("bltu", OP_BR, 3'b110, 32'h204, 32'hFFFF_FFFF, 1, 1'b0, 32'h250, 3'd0, 1'b0, 32'h208, 1'b0);
        issue("bgeu", OP_BR, 3'b111, 32'h204, 32'hFFFF_FFFF, 1, 1'b1, 32'h250, 3'd2, 1'b0, 32'h250, 1'b1);
        check_pred("pred_idx1_cnt2", 32'h204, 1'b1);
        // Invalid funct3: not-taken, redirect undoes the taken guess, no update
        issue("br_f3_010", OP_BR, 3'b010, 32'h204, 7, 7, 1'b1, 32'h250, 3'd0, 1'b1, 32'h208, 1'b0);
        check_pred("pred_no_upd_f3", 32'h204, 1'b1);
        issue("bge_nt", OP_BR, 3'b101, 32'h204, 32'hFFFF_FFFF, 1, 1'b0, 32'h250, 3'd0, 1'b0, 32'h208, 1'b0);
        check_pred("pred_idx1_cnt1", 32'h204, 1'b0);

        // Jumps and other opcodes at index 0 (counter 1): no table change
        issue("jalr", OP_JALR, 3'b000, 32'h300, 0, 0, 1'b0, 32'h2001, 3'd1, 1'b1, 32'h2000, 1'b1);
        issue("jal",  OP_JAL,  3'b000, 32'h300, 0, 0, 1'b0, 32'h3000, 3'd3, 1'b1, 32'h3000, 1'b1);
        check_pred("pred_after_jumps", 32'h300, 1'b0);
        issue("alu",      OP_ALU, 3'b000, 32'h400, 1, 1, 1'b1, 32'h0, 3'd0, 1'b0, 32'h404, 1'b0);
        issue("alu_wrap", OP_ALU, 3'b000, 32'hFFFF_FFFC, 1, 1, 1'b0, 32'h0, 3'd0, 1'b0, 32'h0, 1'b0);
        check_pred("pred_after_alu", 32'h400, 1'b0);

        // Stall: taken branch at pc 0x110 (index 4, counter 1) held 3 cycles
        drive(OP_BR, 3'b000, 32'h110, 9, 9, 1'b0, 32'h180);
        ex_valid = 1'b1;
        ex_stall = 1'b1;
        repeat (3) @(posedge CLK);
        #1;
        ex_valid = 1'b0;
        ex_stall = 1'b0;
        chk("stall_no_res", {31'd0, res_valid}, 32'd0);
        check_pred("stall_no_upd", 32'h110, 1'b0);

        // Collision on index 4: same-cycle lookup sees the old counter
        f_pc = 32'h110;
        #1;
        chk("collide_old", {31'd0, f_pred_taken}, 32'd0);
        issue("beq_collide", OP_BR, 3'b000, 32'h110, 9, 9, 1'b0, 32'h180, 3'd2, 1'b1, 32'h180, 1'b1);
        check_pred("collide_new", 32'h110, 1'b1);

        // Reset coincident with a fire: no result, table back to CNT_INIT
        drive(OP_BR, 3'b000, 32'h110, 9, 9, 1'b0, 32'h180);
        ex_valid = 1'b1;
        RST = 1'b1;
        @(posedge CLK); #1;
        RST = 1'b0;
        ex_valid = 1'b0;
        chk("rst_fire_valid", {31'd0, res_valid}, 32'd0);
        check_pred("rst_fire_table", 32'h110, 1'b0);

        // Three branches, one mispredicted
        issue("perf_b1", OP_BR, 3'b000, 32'h110, 3, 3, 1'b1, 32'h180, 3'd2, 1'b0, 32'h180, 1'b1);
        issue("perf_b2", OP_BR, 3'b000, 32'h110, 3, 3, 1'b0, 32'h180, 3'd2, 1'b1, 32'h180, 1'b1);
        issue("perf_b3", OP_BR, 3'b001, 32'h110, 3, 3, 1'b0, 32'h180, 3'd0, 1'b0, 32'h114, 1'b0);
`ifdef BRANCH_PERF_CNT_EN
        chk("perf_branches",    perf_branches, 32'd3);
        chk("perf_mispredicts", perf_mispredicts, 32'd1);
`endif

        repeat (3) @(posedge CLK);
        #1;
        chk("sb_drained", exp_q.size(), 32'd0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
